// File: rtl/det_job_arbiter_if.sv
// Requester/controller-side signal bundle for det_job_arbiter.
interface det_job_arbiter_if;
  logic [1:0] req;
  logic       dp_ready;
  logic [1:0] gnt;
  logic       sel;
  logic       dp_start;
  logic       dp_abort;
  logic [1:0] done;
  logic [1:0] err;
  logic       busy;
  logic [7:0] jobs;

  // Arbiter side
  modport master (
    input  req, dp_ready,
    output gnt, sel, dp_start, dp_abort, done, err, busy, jobs
  );

  // Requesters plus shared controller side
  modport slave (
    output req, dp_ready,
    input  gnt, sel, dp_start, dp_abort, done, err, busy, jobs
  );
endinterface

// File: rtl/det_job_arbiter.sv
// Round-robin arbiter/sequencer sharing one datapath controller between two
// requesters, with a saturating watchdog that aborts stuck jobs.
module det_job_arbiter #(
  parameter int unsigned TW      = 8,
  parameter int unsigned TIMEOUT = 200
) (
  input  logic               clk,
  input  logic               rst,
  det_job_arbiter_if.master  bus
);

  localparam int unsigned JW = 8;
  localparam logic [TW-1:0] WDOG_MAX = TW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_RUN   = 3'd2,
    S_DONE  = 3'd3,
    S_ABORT = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      gnt_q, gnt_d;
  logic            sel_q, sel_d;
  logic            dp_start_q, dp_start_d;
  logic            dp_abort_q, dp_abort_d;
  logic [1:0]      done_q, done_d;
  logic [1:0]      err_q, err_d;
  logic            busy_q, busy_d;
  logic [JW-1:0]   jobs_q, jobs_d;
  logic            ptr_q, ptr_d;
  logic [TW-1:0]   wdog_q, wdog_d;

  logic            wdog_sat;
  logic [TW-1:0]   wdog_inc;
  logic            pick;

  // Watchdog saturates at the timeout value instead of wrapping
  assign wdog_sat = (wdog_q == WDOG_MAX);
  assign wdog_inc = wdog_sat ? wdog_q : (wdog_q + TW'(1));

  // State register and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      gnt_q      <= 2'b00;
      sel_q      <= 1'b0;
      dp_start_q <= 1'b0;
      dp_abort_q <= 1'b0;
      done_q     <= 2'b00;
      err_q      <= 2'b00;
      busy_q     <= 1'b0;
      jobs_q     <= '0;
      ptr_q      <= 1'b0;
      wdog_q     <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      dp_start_q <= dp_start_d;
      dp_abort_q <= dp_abort_d;
      done_q     <= done_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      jobs_q     <= jobs_d;
      ptr_q      <= ptr_d;
      wdog_q     <= wdog_d;
    end
  end

  // Next state; outputs are computed for the state being entered so they stay Moore
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    ptr_d      = ptr_q;
    jobs_d     = jobs_q;
    wdog_d     = wdog_q;
    dp_start_d = 1'b0;
    dp_abort_d = 1'b0;
    done_d     = 2'b00;
    err_d      = 2'b00;
    pick       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.dp_ready && (bus.req != 2'b00)) begin
          pick       = (bus.req == 2'b11) ? ptr_q : bus.req[1];
          gnt_d      = pick ? 2'b10 : 2'b01;
          sel_d      = pick;
          wdog_d     = '0;
          dp_start_d = 1'b1;
          state_d    = S_START;
        end
      end

      S_START: begin
        wdog_d = wdog_inc;
        // Acceptance beats timeout when both happen together
        if (!bus.dp_ready) begin
          state_d = S_RUN;
        end else if (wdog_sat) begin
          state_d    = S_ABORT;
          dp_abort_d = 1'b1;
          err_d      = gnt_q;
          ptr_d      = ~sel_q;
        end else begin
          dp_start_d = 1'b1;
        end
      end

      S_RUN: begin
        wdog_d = wdog_inc;
        // Completion beats timeout when both happen together
        if (bus.dp_ready) begin
          state_d = S_DONE;
          done_d  = gnt_q;
          jobs_d  = jobs_q + JW'(1);
          ptr_d   = ~sel_q;
        end else if (wdog_sat) begin
          state_d    = S_ABORT;
          dp_abort_d = 1'b1;
          err_d      = gnt_q;
          ptr_d      = ~sel_q;
        end
      end

      S_DONE, S_ABORT: begin
        gnt_d   = 2'b00;
        state_d = S_IDLE;
      end

      default: begin
        gnt_d   = 2'b00;
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy_d = (state_d != S_IDLE);

  assign bus.gnt      = gnt_q;
  assign bus.sel      = sel_q;
  assign bus.dp_start = dp_start_q;
  assign bus.dp_abort = dp_abort_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.busy     = busy_q;
  assign bus.jobs     = jobs_q;

endmodule

// File: tb/tb_det_job_arbiter.sv
// Scoreboard bench for det_job_arbiter with a behavioural shared-controller model.
module tb_det_job_arbiter;

  localparam int unsigned TMO = 30;

  logic clk = 1'b0;
  logic rst = 1'b0;

  det_job_arbiter_if bus ();

  det_job_arbiter #(.TW(8), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic [1:0]  err;
    int unsigned start_len;
    logic [7:0]  jobs;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors     = 0;
  int          miscompares = 0;

  logic [1:0]  req_v  = 2'b00;
  logic        ctl_ready = 1'b1;
  logic        hold_nr = 1'b0;
  int unsigned a_for [2];
  int unsigned r_for [2];

  int          ptr_m  = 0;
  logic [7:0]  jobs_m = 8'd0;

  assign bus.req      = req_v;
  assign bus.dp_ready = ctl_ready & ~hold_nr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Outcome from controller latencies: a = cycles to accept after start seen,
  // r = cycles from acceptance to ready. START+RUN may last TMO+1 cycles.
  function automatic bit job_ok(input int unsigned a, input int unsigned r);
    if (a >= TMO + 1) return 1'b0;
    return (r == 1) || (a + r <= TMO);
  endfunction

  // Shared controller model: accepts start by dropping ready, raises it when finished
  initial begin
    int          c_st;
    int unsigned cnt;
    c_st = 0;
    cnt  = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst || bus.dp_abort) begin
        c_st      = 0;
        ctl_ready = 1'b1;
      end else begin
        case (c_st)
          0: if (bus.dp_start) begin
               cnt  = a_for[bus.sel];
               c_st = 1;
             end
          1: begin
               cnt--;
               if (cnt == 0) begin
                 ctl_ready = 1'b0;
                 cnt       = r_for[bus.sel];
                 c_st      = 2;
               end
             end
          default: begin
               cnt--;
               if (cnt == 0) begin
                 ctl_ready = 1'b1;
                 c_st      = 0;
               end
             end
        endcase
      end
    end
  end

  // Monitor: pops an expectation whenever the DUT reports done or err
  initial begin
    int unsigned slen;
    bit          jchk;
    logic [7:0]  jexp;
    exp_t        e;
    slen = 0;
    jchk = 1'b0;
    jexp = 8'd0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        slen = 0;
        jchk = 1'b0;
      end else begin
        if (jchk) begin
          check("jobs_after_event", 32'(bus.jobs), 32'(jexp));
          check("busy_after_event", 32'(bus.busy), 32'd0);
          check("gnt_after_event", 32'(bus.gnt), 32'd0);
          jchk = 1'b0;
        end
        if (bus.dp_start) slen++;
        if ((bus.done | bus.err) != 2'b00) begin
          if (exp_q.size() == 0) begin
            check("unexpected_event", 32'({bus.done, bus.err}), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("gnt", 32'(bus.gnt), 32'(e.gnt));
            check("sel", 32'(bus.sel), 32'(e.gnt[1]));
            check("done", 32'(bus.done), 32'(e.done));
            check("err", 32'(bus.err), 32'(e.err));
            check("dp_abort", 32'(bus.dp_abort), 32'(e.err != 2'b00));
            check("busy_in_event", 32'(bus.busy), 32'd1);
            check("dp_start_len", 32'(slen), 32'(e.start_len));
            jexp = e.jobs;
            jchk = 1'b1;
          end
          slen = 0;
        end else if (bus.dp_abort) begin
          check("stray_dp_abort", 32'(bus.dp_abort), 32'd0);
        end
      end
    end
  end

  // Issue one job: predict the result, push it, drive req and wait for the outcome
  task automatic do_job(input logic [1:0] rv, input bit keep,
                        input int unsigned a0, input int unsigned r0,
                        input int unsigned a1, input int unsigned r1);
    int          g;
    int unsigned a;
    int unsigned r;
    bit          ok;
    int          waited;
    exp_t        e;
    a_for[0] = a0; r_for[0] = r0;
    a_for[1] = a1; r_for[1] = r1;
    g  = (rv == 2'b11) ? ptr_m : (rv[1] ? 1 : 0);
    a  = (g == 1) ? a1 : a0;
    r  = (g == 1) ? r1 : r0;
    ok = job_ok(a, r);
    e.gnt       = (g == 1) ? 2'b10 : 2'b01;
    e.done      = ok ? e.gnt : 2'b00;
    e.err       = ok ? 2'b00 : e.gnt;
    e.start_len = (a >= TMO + 1) ? TMO + 1 : a + 1;
    if (ok) jobs_m = jobs_m + 8'd1;
    e.jobs = jobs_m;
    ptr_m  = 1 - g;
    exp_q.push_back(e);
    req_v  = rv;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (((bus.done | bus.err) == 2'b00) && (waited < 400));
    if (waited >= 400) check("job_timeout", 32'(waited), 32'd0);
    if (!keep) req_v = rv & ~e.gnt;
  endtask

  initial begin
    logic [1:0] rv;
    a_for[0] = 1; a_for[1] = 1;
    r_for[0] = 1; r_for[1] = 1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_sel", 32'(bus.sel), 32'd0);
    check("rst_dp_start", 32'(bus.dp_start), 32'd0);
    check("rst_dp_abort", 32'(bus.dp_abort), 32'd0);
    check("rst_done_err", 32'({bus.done, bus.err}), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_jobs", 32'(bus.jobs), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Contention: both held, grants alternate starting at 0
    for (int i = 0; i < 4; i++) do_job(2'b11, (i < 3), 1, 9, 1, 9);

    // Single job with 20-cycle run
    do_job(2'b01, 1'b0, 1, 20, 1, 1);

    // Timeout, then next grant goes to the other requester (race in RUN)
    do_job(2'b11, 1'b0, 1, 100, 1, 100);
    do_job(2'b11, 1'b0, 1, TMO - 1, 1, 5);
    if (req_v != 2'b00) do_job(req_v, 1'b0, 2, 3, 2, 3);

    // Watchdog boundaries around acceptance in START
    do_job(2'b10, 1'b0, 1, 1, TMO, 1);
    do_job(2'b01, 1'b0, TMO, 2, 1, 1);
    do_job(2'b10, 1'b0, 1, 1, TMO + 1, 5);

    // Not ready: no grant while dp_ready is low
    @(negedge clk);
    hold_nr  = 1'b1;
    a_for[1] = 2; r_for[1] = 4;
    req_v    = 2'b10;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("nr_gnt_held", 32'(bus.gnt), 32'd0);
    end
    hold_nr = 1'b0;
    @(negedge clk);
    check("nr_gnt_after_ready", 32'(bus.gnt), 32'd2);
    do_job(2'b10, 1'b0, 1, 1, 2, 4);

    // Randomized jobs
    for (int i = 0; i < 40; i++) begin
      rv = req_v | 2'($urandom_range(1, 3));
      do_job(rv, 1'b0, $urandom_range(1, 34), $urandom_range(1, 34),
             $urandom_range(1, 34), $urandom_range(1, 34));
    end
    while (req_v != 2'b00) do_job(req_v, 1'b0, 1, 2, 1, 2);

    // Reset mid-RUN on a requester-1 job
    @(negedge clk);
    a_for[1] = 1; r_for[1] = 100;
    req_v = 2'b10;
    repeat (6) @(negedge clk);
    check("pre_rst_gnt", 32'(bus.gnt), 32'd2);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_gnt", 32'(bus.gnt), 32'd0);
    check("async_rst_dp_start", 32'(bus.dp_start), 32'd0);
    check("async_rst_busy", 32'(bus.busy), 32'd0);
    check("async_rst_jobs", 32'(bus.jobs), 32'd0);
    check("async_rst_sel", 32'(bus.sel), 32'd0);
    exp_q.delete();
    ptr_m  = 0;
    jobs_m = 8'd0;
    req_v  = 2'b11;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    do_job(2'b11, 1'b0, 2, 5, 2, 5);
    do_job(req_v, 1'b0, 2, 5, 2, 5);

    // Job counter wrap with short back-to-back jobs
    for (int i = 0; i < 258; i++) do_job(2'b11, (i < 257), 1, 1, 1, 1);
    req_v = 2'b00;

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
